// File: rtl/evr_time_of_day_transmitter_pkg.sv
// Purpose: shared event codes, FSM state type and defaults for the time-of-day transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package evr_tod_pkg;

  localparam logic [7:0] EVT_IDLE      = 8'h00;
  localparam logic [7:0] EVT_TOD_0     = 8'h70;
  localparam logic [7:0] EVT_TOD_1     = 8'h71;
  localparam logic [7:0] EVT_TOD_LATCH = 8'h7d;

  localparam int TOD_NUM_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2,
    ST_ARMED = 3'd3,
    ST_LATCH = 3'd4
  } tod_state_e;

  // Codes owned by this block; upstream must never emit them.
  function automatic logic is_reserved(input logic [7:0] code);
    return (code == EVT_TOD_0) || (code == EVT_TOD_1) || (code == EVT_TOD_LATCH);
  endfunction

endpackage

// File: rtl/evr_time_of_day_transmitter_if.sv
// Purpose: bundles the seconds/PPS/event-stream signals of the time-of-day transmitter.
// Latency: n/a (wires only).
// Backpressure: none; the event stream is a free-running one-code-per-cycle bus.
// Ports: seconds_in/seconds_load (new seconds), pps_in, event_in (upstream),
//        error_clear, event_out (merged stream), busy, overrun, collision.
interface evr_time_of_day_transmitter_if #(
  parameter int NUM_BITS = 32
);
  logic [NUM_BITS-1:0] seconds_in;
  logic                seconds_load;
  logic                pps_in;
  logic [7:0]          event_in;
  logic                error_clear;
  logic [7:0]          event_out;
  logic                busy;
  logic                overrun;
  logic                collision;

  modport master (
    output seconds_in, seconds_load, pps_in, event_in, error_clear,
    input  event_out, busy, overrun, collision
  );

  modport slave (
    input  seconds_in, seconds_load, pps_in, event_in, error_clear,
    output event_out, busy, overrun, collision
  );
endinterface

// File: rtl/evr_time_of_day_transmitter.sv
// Purpose: serialises a seconds value MSB-first as 0x70/0x71 events into free slots, then 0x7d on PPS.
// Latency: event_out is registered, 1 cycle after event_in.
// Backpressure: none; pending bits wait for a free (0x00) upstream slot, the latch code never waits.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport of evr_time_of_day_transmitter_if).
// Build option: TOD_AUTO_INC_EN -> after each latch the shadow auto-increments and the next
//               transfer starts at once; a load while busy queues the value for the next second.
module evr_time_of_day_transmitter
  import evr_tod_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int NUM_BITS   = TOD_NUM_BITS
) (
  input logic                          clk,
  input logic                          rst_n,
  evr_time_of_day_transmitter_if.slave bus
);

  localparam int                IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_BITS - 1);
  localparam logic [7:0]        GAP_INIT = 8'(GAP_CYCLES);

  tod_state_e          state_q, state_d;
  logic [NUM_BITS-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          gap_q, gap_d;
  logic [7:0]          evt_q, evt_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                collision_q, collision_d;
  logic                ovr_set, col_set, latch_req;
`ifdef TOD_AUTO_INC_EN
  logic [NUM_BITS-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
`endif

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    busy_d    = busy_q;
    evt_d     = bus.event_in;
    ovr_set   = 1'b0;
    col_set   = 1'b0;
    latch_req = 1'b0;
`ifdef TOD_AUTO_INC_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`endif

    // Upstream must not forge our codes; blank the slot and flag it.
    if (is_reserved(bus.event_in)) begin
      evt_d   = EVT_IDLE;
      col_set = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.seconds_load) begin
          shadow_d = bus.seconds_in;
          idx_d    = IDX_MAX;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.pps_in) begin
          latch_req = 1'b1;
          ovr_set   = 1'b1;
        end else if (bus.event_in == EVT_IDLE) begin
          evt_d = shadow_q[idx_q] ? EVT_TOD_1 : EVT_TOD_0;
          if (idx_q == '0) begin
            state_d = ST_ARMED;
          end else begin
            idx_d   = idx_q - 1'b1;
            gap_d   = GAP_INIT;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (bus.pps_in) begin
          latch_req = 1'b1;
          ovr_set   = 1'b1;
        end else begin
          // Leave as the count reaches zero so GAP_CYCLES idle slots separate bits.
          gap_d = (gap_q == 8'd0) ? 8'd0 : gap_q - 8'd1;
          if (gap_d == 8'd0) state_d = ST_SHIFT;
        end
      end
      ST_ARMED: begin
        if (bus.pps_in) latch_req = 1'b1;
      end
      ST_LATCH: begin
`ifdef TOD_AUTO_INC_EN
        shadow_d   = pend_vld_q ? pend_q : shadow_q + NUM_BITS'(1);
        pend_vld_d = 1'b0;
        if (bus.seconds_load) shadow_d = bus.seconds_in;
        idx_d      = IDX_MAX;
        busy_d     = 1'b1;
        state_d    = ST_SHIFT;
`else
        // 0x7d is already on the wire; this cycle behaves like IDLE.
        state_d = ST_IDLE;
        if (bus.seconds_load) begin
          shadow_d = bus.seconds_in;
          idx_d    = IDX_MAX;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TOD_AUTO_INC_EN
    if (bus.seconds_load && busy_q && (state_q != ST_LATCH)) begin
      pend_d     = bus.seconds_in;
      pend_vld_d = 1'b1;
    end
`endif

    // The time base wins the slot: any upstream code in it is lost.
    if (latch_req) begin
      evt_d   = EVT_TOD_LATCH;
      col_set = (bus.event_in != EVT_IDLE);
      state_d = ST_LATCH;
`ifdef TOD_AUTO_INC_EN
      busy_d  = 1'b1;
`else
      busy_d  = 1'b0;
`endif
    end

    overrun_d   = ovr_set ? 1'b1 : (bus.error_clear ? 1'b0 : overrun_q);
    collision_d = col_set ? 1'b1 : (bus.error_clear ? 1'b0 : collision_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      gap_q       <= 8'd0;
      evt_q       <= EVT_IDLE;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      collision_q <= 1'b0;
`ifdef TOD_AUTO_INC_EN
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      evt_q       <= evt_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      collision_q <= collision_d;
`ifdef TOD_AUTO_INC_EN
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
`endif
    end
  end

  assign bus.event_out = evt_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_evr_time_of_day_transmitter.sv
// Purpose: directed self-checking bench for evr_time_of_day_transmitter (default build).
// Latency: n/a.
// Backpressure: n/a.
module tb_evr_time_of_day_transmitter;
  import evr_tod_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  evr_time_of_day_transmitter_if #(.NUM_BITS(32)) tb_if ();

  evr_time_of_day_transmitter #(.GAP_CYCLES(4), .NUM_BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tb_if.slave)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Gather bit events (ignoring idle/upstream slots) and check them MSB-first.
  task automatic collect_bits(input logic [31:0] val, input int first, input int last);
    int nb;
    int cyc;
    logic [7:0] exp;
    nb  = first;
    cyc = 0;
    while (nb < last && cyc < 600) begin
      tick();
      cyc++;
      if (tb_if.event_out == EVT_TOD_0 || tb_if.event_out == EVT_TOD_1) begin
        exp = val[31-nb] ? 8'h71 : 8'h70;
        chk("bit_order", 32'(tb_if.event_out), 32'(exp));
        nb++;
      end
    end
    chk("bit_count", 32'(nb), 32'(last));
  endtask

  task automatic load(input logic [31:0] val);
    tb_if.seconds_in   = val;
    tb_if.seconds_load = 1'b1;
    tick();
    tb_if.seconds_load = 1'b0;
  endtask

  task automatic pps();
    tb_if.pps_in = 1'b1;
    tick();
    tb_if.pps_in = 1'b0;
  endtask

  initial begin
    logic [31:0] v1;
    logic [7:0]  exp;
    tb_if.seconds_in   = '0;
    tb_if.seconds_load = 1'b0;
    tb_if.pps_in       = 1'b0;
    tb_if.event_in     = 8'h00;
    tb_if.error_clear  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_event_out", 32'(tb_if.event_out), 32'h00);
    chk("rst_busy", 32'(tb_if.busy), 32'd0);
    chk("rst_overrun", 32'(tb_if.overrun), 32'd0);
    chk("rst_collision", 32'(tb_if.collision), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full transfer of 0x80000001 with 4-slot gaps; a load mid-transfer is ignored
    v1 = 32'h8000_0001;
    load(v1);
    chk("t1_busy_after_load", 32'(tb_if.busy), 32'd1);
    chk("t1_out_after_load", 32'(tb_if.event_out), 32'h00);
    for (int i = 0; i < 32; i++) begin
      tick();
      exp = v1[31-i] ? 8'h71 : 8'h70;
      chk("t1_bit", 32'(tb_if.event_out), 32'(exp));
      if (i < 31) begin
        for (int j = 0; j < 4; j++) begin
          if (i == 3 && j == 0) begin
            tb_if.seconds_in   = 32'hFFFF_FFFF;
            tb_if.seconds_load = 1'b1;
          end
          tick();
          tb_if.seconds_load = 1'b0;
          chk("t1_gap", 32'(tb_if.event_out), 32'h00);
        end
      end
    end
    for (int k = 0; k < 43; k++) begin
      tick();
      chk("t1_armed_idle", 32'(tb_if.event_out), 32'h00);
    end
    chk("t1_busy_armed", 32'(tb_if.busy), 32'd1);
    pps();
    chk("t1_latch", 32'(tb_if.event_out), 32'h7d);
    chk("t1_busy_fall", 32'(tb_if.busy), 32'd0);
    chk("t1_overrun", 32'(tb_if.overrun), 32'd0);
    chk("t1_collision", 32'(tb_if.collision), 32'd0);
    tick();
    chk("t1_after_latch", 32'(tb_if.event_out), 32'h00);

    // Upstream 0x2A held for 10 cycles stalls the bit stream
    load(32'h1234_5678);
    tb_if.event_in = 8'h2a;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2_passthru", 32'(tb_if.event_out), 32'h2a);
    end
    tb_if.event_in = 8'h00;
    collect_bits(32'h1234_5678, 0, 32);
    pps();
    chk("t2_latch", 32'(tb_if.event_out), 32'h7d);
    chk("t2_collision", 32'(tb_if.collision), 32'd0);
    chk("t2_busy", 32'(tb_if.busy), 32'd0);

    // PPS after 12 bits: overrun, remaining bits discarded
    load(32'hFFFF_0000);
    collect_bits(32'hFFFF_0000, 0, 12);
    pps();
    chk("t3_latch", 32'(tb_if.event_out), 32'h7d);
    chk("t3_overrun", 32'(tb_if.overrun), 32'd1);
    chk("t3_busy", 32'(tb_if.busy), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_no_more_bits", 32'(tb_if.event_out), 32'h00);
    end
    tb_if.error_clear = 1'b1;
    tick();
    tb_if.error_clear = 1'b0;
    chk("t3_overrun_clear", 32'(tb_if.overrun), 32'd0);

    // PPS in ARMED with 0x55 in the same slot
    load(32'h0000_0003);
    collect_bits(32'h0000_0003, 0, 32);
    tick();
    tb_if.event_in = 8'h55;
    pps();
    tb_if.event_in = 8'h00;
    chk("t4_latch", 32'(tb_if.event_out), 32'h7d);
    chk("t4_collision", 32'(tb_if.collision), 32'd1);
    chk("t4_overrun", 32'(tb_if.overrun), 32'd0);
    tick();
    chk("t4_55_lost", 32'(tb_if.event_out), 32'h00);
    tb_if.error_clear = 1'b1;
    tick();
    tb_if.error_clear = 1'b0;
    chk("t4_collision_clear", 32'(tb_if.collision), 32'd0);

    // Reserved code from upstream in IDLE, pass-through, set beats clear
    tb_if.event_in = 8'h7d;
    tick();
    tb_if.event_in = 8'h33;
    chk("t5_reserved_blank", 32'(tb_if.event_out), 32'h00);
    chk("t5_collision", 32'(tb_if.collision), 32'd1);
    tick();
    chk("t5_passthru", 32'(tb_if.event_out), 32'h33);
    chk("t5_collision_sticky", 32'(tb_if.collision), 32'd1);
    tb_if.event_in    = 8'h71;
    tb_if.error_clear = 1'b1;
    tick();
    tb_if.event_in = 8'h00;
    chk("t5_set_wins", 32'(tb_if.collision), 32'd1);
    chk("t5_reserved_blank2", 32'(tb_if.event_out), 32'h00);
    tick();
    tb_if.error_clear = 1'b0;
    chk("t5_clear", 32'(tb_if.collision), 32'd0);

    // PPS in IDLE has no effect
    pps();
    chk("t6_pps_idle_out", 32'(tb_if.event_out), 32'h00);
    chk("t6_pps_idle_busy", 32'(tb_if.busy), 32'd0);
    chk("t6_pps_idle_ovr", 32'(tb_if.overrun), 32'd0);

    // Load and PPS together in IDLE: load only
    tb_if.seconds_in   = 32'h8000_0000;
    tb_if.seconds_load = 1'b1;
    tb_if.pps_in       = 1'b1;
    tick();
    tb_if.seconds_load = 1'b0;
    tb_if.pps_in       = 1'b0;
    chk("t7_busy", 32'(tb_if.busy), 32'd1);
    chk("t7_out", 32'(tb_if.event_out), 32'h00);
    chk("t7_overrun", 32'(tb_if.overrun), 32'd0);
    tick();
    chk("t7_first_bit", 32'(tb_if.event_out), 32'h71);

    // Reset mid-SHIFT abandons the transfer
    rst_n = 1'b0;
    tick();
    chk("t8_rst_out", 32'(tb_if.event_out), 32'h00);
    chk("t8_rst_busy", 32'(tb_if.busy), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t8_no_bits", 32'(tb_if.event_out), 32'h00);
    end
    pps();
    chk("t8_no_latch", 32'(tb_if.event_out), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
